// File: rtl/snoop_pkg.sv
// rtl/snoop_pkg.sv - shared constants, state encoding and helpers for the snoop bus controller
//
// Provides the bus opcodes, the controller state enum, the fixed bus
// dimensions (three caches, 2-bit tags, 4-bit data) and a one-hot to
// index helper used by the controller.
package snoop_pkg;

    localparam int N_PROC = 3;
    localparam int TAG_W  = 2;
    localparam int DATA_W = 4;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_RM   = 2'd1;
    localparam logic [1:0] OP_WM   = 2'd2;
    localparam logic [1:0] OP_WB   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SNOOP,
        ST_MEM,
        ST_DONE
    } state_e;

    function automatic logic [1:0] oh_to_idx(input logic [N_PROC-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational one-hot winner selection among the cache requesters
//
// Ports:
//   req_mask  in   N_PROC  requests eligible for arbitration
//   ptr       in   2       index of the previous winner
//   win       out  N_PROC  one-hot winner, all zero when req_mask is zero
// Macro SNOOP_ARB_RR_EN: when defined, the search starts at (ptr + 1) mod 3;
// otherwise cache 0 always has highest priority and ptr is ignored.
module rr_picker
    import snoop_pkg::*;
(
    input  logic [N_PROC-1:0] req_mask,
    input  logic [1:0]        ptr,
    output logic [N_PROC-1:0] win
);

    localparam logic [N_PROC-1:0] ONE = 1;

    // First set bit of m when visiting indices in the order a, b, c.
    function automatic logic [N_PROC-1:0] first_set(
        input logic [N_PROC-1:0] m,
        input logic [1:0]        a,
        input logic [1:0]        b,
        input logic [1:0]        c
    );
        if (m[a]) return ONE << a;
        if (m[b]) return ONE << b;
        if (m[c]) return ONE << c;
        return '0;
    endfunction

`ifdef SNOOP_ARB_RR_EN
    always_comb begin
        win = '0;
        case (ptr)
            2'd0:    win = first_set(req_mask, 2'd1, 2'd2, 2'd0);
            2'd1:    win = first_set(req_mask, 2'd2, 2'd0, 2'd1);
            default: win = first_set(req_mask, 2'd0, 2'd1, 2'd2);
        endcase
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        win = first_set(req_mask, 2'd0, 2'd1, 2'd2);
    end
`endif

endmodule

// File: rtl/snoop_bus_ctrl.sv
// rtl/snoop_bus_ctrl.sv - arbiter and phase sequencer for the shared snooping cache bus
//
// Grants one of three caches, broadcasts its transaction (ADDR), collects
// snoop responses (SNOOP), performs the memory access (MEM) and returns the
// result with a one-cycle ack (DONE).
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   req/req_op/req_tag/req_data       per-cache request level, opcode, tag, writeback data
//   snoop_hit/snoop_data              per-cache Modified-hit flag and flush data
//   mem_rdata/mem_ready               memory read data and completion strobe
//   gnt/ack                           one-hot grant (ADDR..DONE) and completion pulse
//   bus_valid/bus_op/bus_src/bus_tag  broadcast message, valid in ADDR only
//   bus_data                          result data, valid in DONE only
//   mem_rd/mem_wr/mem_addr/mem_wdata  memory access, held in MEM until mem_ready
//   busy                              controller is not idle
// Macro SNOOP_ARB_RR_EN: round-robin arbitration (pointer resets to 2);
// fixed priority 0 > 1 > 2 when undefined.
module snoop_bus_ctrl
    import snoop_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_PROC-1:0]        req,
    input  logic [2*N_PROC-1:0]      req_op,
    input  logic [TAG_W*N_PROC-1:0]  req_tag,
    input  logic [DATA_W*N_PROC-1:0] req_data,
    input  logic [N_PROC-1:0]        snoop_hit,
    input  logic [DATA_W*N_PROC-1:0] snoop_data,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic [N_PROC-1:0]        gnt,
    output logic [N_PROC-1:0]        ack,
    output logic                     bus_valid,
    output logic [1:0]               bus_op,
    output logic [1:0]               bus_src,
    output logic [TAG_W-1:0]         bus_tag,
    output logic [DATA_W-1:0]        bus_data,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [TAG_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     busy
);

    state_e state, state_next;

    logic [1:0]        cur_op;
    logic [1:0]        cur_src;
    logic [TAG_W-1:0]  cur_tag;
    // Holds writeback data, then the snoop flush data or the memory read
    // data, so it always carries the transaction result by DONE.
    logic [DATA_W-1:0] xfer_data;
    logic              mem_write;
    logic [1:0]        rr_ptr;

    logic [N_PROC-1:0] req_valid;
    logic [N_PROC-1:0] win;
    logic [1:0]        sel_op;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;
    logic [N_PROC-1:0] snoop_other;
    logic [DATA_W-1:0] hit_data;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < N_PROC; i++) begin
            req_valid[i] = req[i] && (req_op[2*i +: 2] != OP_NONE);
        end
    end

    rr_picker u_picker (
        .req_mask (req_valid),
        .ptr      (rr_ptr),
        .win      (win)
    );

    always_comb begin
        sel_op   = OP_NONE;
        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (win[i]) begin
                sel_op   = req_op[2*i +: 2];
                sel_tag  = req_tag[TAG_W*i +: TAG_W];
                sel_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // The requester's own hit is not a sharer; of the rest, the lowest index
    // supplies the flush data (scan downward so the lowest assignment wins).
    always_comb begin
        snoop_other = snoop_hit & ~gnt;
        hit_data    = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (snoop_other[i]) hit_data = snoop_data[DATA_W*i +: DATA_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ack        = '0;
        bus_valid  = 1'b0;
        bus_op     = OP_NONE;
        bus_src    = '0;
        bus_tag    = '0;
        bus_data   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (|req_valid) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                bus_valid  = 1'b1;
                bus_op     = cur_op;
                bus_src    = cur_src;
                bus_tag    = cur_tag;
                state_next = (cur_op == OP_WB) ? ST_MEM : ST_SNOOP;
            end
            ST_SNOOP: begin
                state_next = ST_MEM;
            end
            ST_MEM: begin
                mem_rd   = !mem_write;
                mem_wr   = mem_write;
                mem_addr = cur_tag;
                if (mem_write) mem_wdata = xfer_data;
                if (mem_ready) state_next = ST_DONE;
            end
            ST_DONE: begin
                ack        = gnt;
                bus_data   = xfer_data;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt       <= '0;
            cur_op    <= OP_NONE;
            cur_src   <= '0;
            cur_tag   <= '0;
            xfer_data <= '0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        gnt       <= win;
                        cur_src   <= oh_to_idx(win);
                        cur_op    <= sel_op;
                        cur_tag   <= sel_tag;
                        xfer_data <= sel_data;
                    end
                end
                ST_ADDR: begin
                    mem_write <= (cur_op == OP_WB);
                end
                ST_SNOOP: begin
                    mem_write <= |snoop_other;
                    if (|snoop_other) xfer_data <= hit_data;
                end
                ST_MEM: begin
                    if (mem_ready && !mem_write) xfer_data <= mem_rdata;
                end
                ST_DONE: begin
                    gnt <= '0;
                end
                default: gnt <= '0;
            endcase
        end
    end

`ifdef SNOOP_ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= 2'd2;
        end else if (state == ST_IDLE && (|req_valid)) begin
            rr_ptr <= oh_to_idx(win);
        end
    end
`else
    assign rr_ptr = 2'd2;
`endif

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb/tb_snoop_bus_ctrl.sv - directed self-checking bench for snoop_bus_ctrl
module tb_snoop_bus_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [5:0]  req_op;
    logic [5:0]  req_tag;
    logic [11:0] req_data;
    logic [2:0]  snoop_hit;
    logic [11:0] snoop_data;
    logic [3:0]  mem_rdata;
    logic        mem_ready;
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic        bus_valid;
    logic [1:0]  bus_op;
    logic [1:0]  bus_src;
    logic [1:0]  bus_tag;
    logic [3:0]  bus_data;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_addr;
    logic [3:0]  mem_wdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    snoop_bus_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_op     (req_op),
        .req_tag    (req_tag),
        .req_data   (req_data),
        .snoop_hit  (snoop_hit),
        .snoop_data (snoop_data),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .gnt        (gnt),
        .ack        (ack),
        .bus_valid  (bus_valid),
        .bus_op     (bus_op),
        .bus_src    (bus_src),
        .bus_tag    (bus_tag),
        .bus_data   (bus_data),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [1:0] tag, input logic [3:0] d);
        req_op[2*i +: 2]   = op;
        req_tag[2*i +: 2]  = tag;
        req_data[4*i +: 4] = d;
    endtask

    function automatic logic [28:0] all_outs();
        return {gnt, ack, bus_valid, bus_op, bus_src, bus_tag, bus_data,
                mem_rd, mem_wr, mem_addr, mem_wdata, busy};
    endfunction

    task automatic test_reset();
        reset = 1'b1; req = '0; req_op = '0; req_tag = '0; req_data = '0;
        snoop_hit = '0; snoop_data = '0; mem_rdata = '0; mem_ready = 1'b1;
        tick(); tick();
        total++; if (all_outs() !== 29'd0) begin bad++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
        reset = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_rm_miss();
        set_req(1, 2'd1, 2'd2, 4'h3); req = 3'b010; mem_rdata = 4'hA; mem_ready = 1'b1; snoop_hit = '0;
        tick();
        total++; if ({bus_valid, bus_op, bus_src, bus_tag, gnt} !== {1'b1, 2'd1, 2'd1, 2'd2, 3'b010}) begin
            bad++; $display("FAIL rm_addr_phase: got v=%b op=%0d src=%0d tag=%0d gnt=%b expected v=1 op=1 src=1 tag=2 gnt=010",
                            bus_valid, bus_op, bus_src, bus_tag, gnt); end
        set_req(1, 2'd3, 2'd0, 4'hF);
        tick();
        total++; if ({bus_valid, mem_rd, mem_wr, busy} !== 4'b0001) begin
            bad++; $display("FAIL rm_snoop_phase: got v=%b rd=%b wr=%b busy=%b expected 0 0 0 1", bus_valid, mem_rd, mem_wr, busy); end
        tick();
        total++; if ({mem_rd, mem_wr, mem_addr, gnt} !== {1'b1, 1'b0, 2'd2, 3'b010}) begin
            bad++; $display("FAIL rm_mem_read: got rd=%b wr=%b addr=%0d gnt=%b expected rd=1 wr=0 addr=2 gnt=010", mem_rd, mem_wr, mem_addr, gnt); end
        tick();
        total++; if ({ack, bus_data} !== {3'b010, 4'hA}) begin
            bad++; $display("FAIL rm_ack: got ack=%b data=%h expected ack=010 data=a", ack, bus_data); end
        req = '0;
        tick();
        total++; if ({busy, gnt, ack} !== 7'd0) begin
            bad++; $display("FAIL rm_return_idle: got busy=%b gnt=%b ack=%b expected all 0", busy, gnt, ack); end
    endtask

    task automatic test_rm_flush();
        set_req(0, 2'd1, 2'd1, 4'h0); req = 3'b001; snoop_hit = 3'b100;
        snoop_data = {4'h5, 4'h9, 4'h9}; mem_rdata = 4'hE; mem_ready = 1'b1;
        tick();
        total++; if ({gnt, bus_src} !== {3'b001, 2'd0}) begin
            bad++; $display("FAIL flush_grant: got gnt=%b src=%0d expected gnt=001 src=0", gnt, bus_src); end
        tick(); tick();
        total++; if ({mem_wr, mem_rd, mem_wdata, mem_addr} !== {1'b1, 1'b0, 4'h5, 2'd1}) begin
            bad++; $display("FAIL flush_mem_write: got wr=%b rd=%b wdata=%h addr=%0d expected wr=1 rd=0 wdata=5 addr=1",
                            mem_wr, mem_rd, mem_wdata, mem_addr); end
        tick();
        total++; if ({ack, bus_data} !== {3'b001, 4'h5}) begin
            bad++; $display("FAIL flush_ack: got ack=%b data=%h expected ack=001 data=5", ack, bus_data); end
        req = '0; snoop_hit = '0;
        tick();
    endtask

    task automatic test_self_hit();
        set_req(0, 2'd2, 2'd3, 4'h0); req = 3'b001; snoop_hit = 3'b001;
        snoop_data = {4'h5, 4'h5, 4'h5}; mem_rdata = 4'hC; mem_ready = 1'b1;
        tick(); tick(); tick();
        total++; if ({mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b0, 2'd3}) begin
            bad++; $display("FAIL self_hit_read: got rd=%b wr=%b addr=%0d expected rd=1 wr=0 addr=3", mem_rd, mem_wr, mem_addr); end
        tick();
        total++; if ({ack, bus_data} !== {3'b001, 4'hC}) begin
            bad++; $display("FAIL self_hit_ack: got ack=%b data=%h expected ack=001 data=c", ack, bus_data); end
        req = '0; snoop_hit = '0;
        tick();
    endtask

    task automatic test_lowest_hitter();
        set_req(2, 2'd1, 2'd0, 4'h0); req = 3'b100; snoop_hit = 3'b111;
        snoop_data = {4'h8, 4'h3, 4'h6}; mem_rdata = 4'h1; mem_ready = 1'b1;
        tick(); tick(); tick();
        total++; if ({mem_wr, mem_rd, mem_wdata} !== {1'b1, 1'b0, 4'h6}) begin
            bad++; $display("FAIL lowest_hitter: got wr=%b rd=%b wdata=%h expected wr=1 rd=0 wdata=6", mem_wr, mem_rd, mem_wdata); end
        tick();
        total++; if ({ack, bus_data} !== {3'b100, 4'h6}) begin
            bad++; $display("FAIL lowest_hitter_ack: got ack=%b data=%h expected ack=100 data=6", ack, bus_data); end
        req = '0; snoop_hit = '0;
        tick();
    endtask

    task automatic test_wb_stall();
        int wr_cycles;
        int early_acks;
        wr_cycles = 0; early_acks = 0;
        set_req(2, 2'd3, 2'd3, 4'h7); req = 3'b100; mem_ready = 1'b0; snoop_hit = '0;
        tick();
        total++; if ({bus_valid, bus_op, bus_src, bus_tag} !== {1'b1, 2'd3, 2'd2, 2'd3}) begin
            bad++; $display("FAIL wb_addr_phase: got v=%b op=%0d src=%0d tag=%0d expected v=1 op=3 src=2 tag=3",
                            bus_valid, bus_op, bus_src, bus_tag); end
        for (int k = 0; k < 4; k++) begin
            tick();
            mem_ready = (k == 3);
            if (mem_wr === 1'b1 && mem_wdata === 4'h7 && mem_addr === 2'd3) wr_cycles++;
            if (ack !== 3'b000) early_acks++;
        end
        total++; if (wr_cycles !== 4) begin bad++; $display("FAIL wb_write_held: got %0d cycles expected 4", wr_cycles); end
        total++; if (early_acks !== 0) begin bad++; $display("FAIL wb_early_ack: got %0d expected 0", early_acks); end
        tick();
        total++; if ({ack, bus_data, mem_wr} !== {3'b100, 4'h7, 1'b0}) begin
            bad++; $display("FAIL wb_ack: got ack=%b data=%h wr=%b expected ack=100 data=7 wr=0", ack, bus_data, mem_wr); end
        req = '0; mem_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_order [4];
`ifdef SNOOP_ARB_RR_EN
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_order = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        reset = 1'b1; tick(); reset = 1'b0;
        set_req(0, 2'd1, 2'd0, 4'h0); set_req(1, 2'd1, 2'd1, 4'h0); set_req(2, 2'd1, 2'd2, 4'h0);
        req = 3'b111; mem_ready = 1'b1; snoop_hit = '0; mem_rdata = 4'h2;
        for (int n = 0; n < 4; n++) begin
            tick();
            total++; if (gnt !== exp_order[n]) begin
                bad++; $display("FAIL arb_grant_%0d: got %b expected %b", n, gnt, exp_order[n]); end
            tick(); tick(); tick();
            total++; if (ack !== exp_order[n]) begin
                bad++; $display("FAIL arb_ack_%0d: got %b expected %b", n, ack, exp_order[n]); end
            req = req & ~ack;
            tick();
            total++; if ({busy, gnt} !== 4'd0) begin
                bad++; $display("FAIL arb_idle_gap_%0d: got busy=%b gnt=%b expected 0 000", n, busy, gnt); end
            req = 3'b111;
        end
        tick();
        req = '0;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_reset_mid();
        set_req(1, 2'd1, 2'd1, 4'h0); req = 3'b010; mem_ready = 1'b0; snoop_hit = '0;
        tick(); tick(); tick();
        total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL mid_in_mem: got rd=%b expected 1", mem_rd); end
        reset = 1'b1;
        tick();
        total++; if (all_outs() !== 29'd0) begin
            bad++; $display("FAIL mid_reset_outputs: got %h expected 0", all_outs()); end
        reset = 1'b0; req = '0;
        tick();
        total++; if ({busy, ack} !== 4'd0) begin
            bad++; $display("FAIL mid_reset_no_ack: got busy=%b ack=%b expected 0 000", busy, ack); end
        set_req(0, 2'd1, 2'd0, 4'h0); set_req(1, 2'd1, 2'd1, 4'h0); set_req(2, 2'd1, 2'd2, 4'h0);
        req = 3'b111; mem_ready = 1'b1;
        tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL mid_first_grant: got %b expected 001", gnt); end
        tick(); tick(); tick();
        total++; if (ack !== 3'b001) begin bad++; $display("FAIL mid_first_ack: got %b expected 001", ack); end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rm_miss();
        test_rm_flush();
        test_self_hit();
        test_lowest_hitter();
        test_wb_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snoop_bus_ctrl.md
# snoop_bus_ctrl

Sequencer and arbiter for the shared snooping bus between the three processor caches and main memory. Grants one cache at a time, broadcasts its transaction on the bus, collects snoop responses, drives the memory read/write, and returns data and an acknowledge to the requester. It replaces the free-running step counter as the source of bus phase ordering.

## Interface
Parameters:
- N_PROC, 3, number of caches (requesters and snoopers); fixed at 3 in this revision
- TAG_W, 2, block tag width
- DATA_W, 4, block data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_PROC  per-cache request, level, held until ack
- req_op  in  2*N_PROC  per-cache opcode, slice i = bits [2i+1:2i]
- req_tag  in  TAG_W*N_PROC  per-cache tag
- req_data  in  DATA_W*N_PROC  per-cache writeback data
- snoop_hit  in  N_PROC  cache i holds the broadcast tag Modified
- snoop_data  in  DATA_W*N_PROC  per-cache data for a snoop hit
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completes the access this cycle
- gnt  out  N_PROC  one-hot grant
- ack  out  N_PROC  one-hot, one-cycle completion pulse
- bus_valid  out  1  broadcast phase active
- bus_op  out  2; bus_src  out  2; bus_tag  out  TAG_W  broadcast message
- bus_data  out  DATA_W  result data
- mem_rd  out  1; mem_wr  out  1; mem_addr  out  TAG_W; mem_wdata  out  DATA_W
- busy  out  1  state is not IDLE

## Operation
- Opcodes: 0 NONE, 1 RM (read miss), 2 WM (write miss / invalidate), 3 WB (writeback). req with op NONE is not a request.
- States: IDLE, ADDR, SNOOP, MEM, DONE.
- IDLE: if any valid request, pick winner w; latch op, tag, and req_data[w]; gnt=onehot(w); go to ADDR. Otherwise stay.
- ADDR: bus_valid=1, bus_op=op, bus_src=w, bus_tag=tag for exactly one cycle. WB → MEM (write, mem_wdata=latched data). RM/WM → SNOOP.
- SNOOP: sample snoop_hit with bit w masked. If any hit: take snoop_data of the lowest-index hitter as result; go to MEM as a flush write of that data. No hit: go to MEM as a read.
- MEM: mem_rd or mem_wr held with mem_addr=tag until the cycle mem_ready=1. On a read, capture mem_rdata as result. Then go to DONE.
- DONE: ack[w]=1 for one cycle; bus_data=result (WB: the written data); gnt cleared on exit; go to IDLE.
- Requester must drop req at the clock edge where its ack is high; the next IDLE therefore does not re-grant it.
- Inputs req_op/req_tag/req_data changing after grant are ignored (latched).
- Reset value of every output: 0. Internal round-robin pointer resets to 2, so cache 0 has first priority.
- Reset mid-transaction: return to IDLE next cycle, transaction dropped, no ack, mem_rd/mem_wr low.

## Timing
- Minimum latency: request sampled in IDLE at cycle 0, ADDR at cycle 1, SNOOP at cycle 2, MEM at cycle 3, ack at cycle 4 when mem_ready=1 in cycle 3. WB skips SNOOP: ack at cycle 3.
- Each cycle mem_ready is low in MEM adds one cycle; no timeout.
- gnt is stable from ADDR through DONE; bus_data is valid only in DONE.
- Back-to-back: next grant no earlier than the IDLE cycle following DONE.

## Configuration
- SNOOP_ARB_RR_EN defined: round-robin priority starting at (last winner + 1) mod 3; pointer updates at each grant.
- Not defined: fixed priority with cache 0 highest, then 1, then 2; pointer logic absent.

## Structure
- Shared package snoop_pkg: opcode constants (OP_NONE, OP_RM, OP_WM, OP_WB), state enum, N_PROC, TAG_W, DATA_W.
- Sub-module rr_picker: combinational one-hot winner from req mask and pointer (fixed priority when the macro is off).

## Test plan
- Single RM from cache 1, tag 2, no snoop hit, mem_rdata=0xA, mem_ready tied 1 → bus_op=1, bus_src=1 in ADDR; mem_rd at cycle 3; ack[1] at cycle 4 with bus_data=0xA.
- RM from cache 0, snoop_hit=3'b100 with snoop_data[2]=0x5 → mem_wr with mem_wdata=0x5 and no mem_rd; ack[0] with bus_data=0x5. Self-hit snoop_hit=3'b001 is ignored, so a memory read occurs.
- WB from cache 2, data 0x7, mem_ready low 3 cycles → mem_wr held 4 cycles; no SNOOP state; ack[2] follows.
- All three request simultaneously and continuously (with SNOOP_ARB_RR_EN) → grant order 0,1,2,0. Without the macro, with cache 0 re-requesting after each ack → cache 0 wins every arbitration.
- reset asserted during MEM → next cycle all outputs 0, no ack, state IDLE; the following request is granted to cache 0 first.
